op_phase_accumulator: RTL and testbench
=======================================

// Module: op_phase_accumulator
//
// PURPOSE
// - Per-operator phase accumulator (NCO core) consuming the phase increment produced upstream.
// - Holds one accumulator per time-multiplexed operator slot; adds the increment on each slot visit.
// - Applies key-on phase reset and FM modulation; emits a truncated phase to the sine/exp lookup.
// - Sits between the phase-increment stage and the waveform ROM in the operator pipeline.
//
// PARAMETERS
// NUM_OPS          18  operator slots; legal op_num range 0..NUM_OPS-1
// PHASE_ACC_WIDTH  20  accumulator width in bits; matches phase_inc width
// PHASE_OUT_WIDTH  10  phase bits delivered to the waveform stage (MSBs of accumulator)
// MOD_WIDTH        10  signed modulation input width
//
// PORTS
// clk            in   1                 system clock
// reset          in   1                 asynchronous, active-high reset
// sample_clk_en  in   1                 slot strobe; one operator is processed per strobed cycle
// op_num         in   $clog2(NUM_OPS)   operator slot for this strobe
// phase_inc      in   PHASE_ACC_WIDTH   unsigned increment for op_num, aligned with strobe
// key_on         in   1                 current key-on state of op_num's channel
// modulation     in   MOD_WIDTH         signed phase offset (feedback/FM), aligned with strobe
// phase_out      out  PHASE_OUT_WIDTH   modulated phase for op_num_out
// op_num_out     out  $clog2(NUM_OPS)   slot number tagging phase_out
// phase_valid    out  1                 one-cycle pulse qualifying phase_out/op_num_out
//
// BEHAVIOUR
// - State: acc[NUM_OPS] (PHASE_ACC_WIDTH each), key_prev[NUM_OPS] (1 bit each); flops, not RAM.
// - reset asserted (any time, incl. mid-sequence): all acc, key_prev, phase_out, op_num_out,
//   phase_valid forced to 0 immediately; first strobe after deassert starts from phase 0.
// - Strobe cycle N (sample_clk_en=1, op_num<NUM_OPS):
//   key_rise = key_on & ~key_prev[op_num]; key_prev[op_num] <= key_on.
//   acc_next = key_rise ? 0 (see CONFIGURATION) : acc[op_num] + phase_inc, wrap mod 2^PHASE_ACC_WIDTH.
//   acc[op_num] <= acc_next.
// - Cycle N+1 (latency exactly 1): phase_valid=1, op_num_out=op_num,
//   phase_out = acc_next[MSB -: PHASE_OUT_WIDTH] + modulation (sign-extended/truncated to
//   PHASE_OUT_WIDTH), wrap mod 2^PHASE_OUT_WIDTH; no saturation.
// - No strobe: no state change; phase_valid=0; phase_out/op_num_out hold last value.
// - op_num >= NUM_OPS with strobe: ignored (no state write, phase_valid=0 next cycle).
// - Same op_num on consecutive strobes: second access sees first's written acc (no stale read).
// - Key-off (key_on falling): no phase action; accumulator keeps running.
// - phase_inc=0: acc holds, phase_out tracks modulation only.
// - Slots are independent; a strobe never alters another slot's acc or key_prev.
//
// CONFIGURATION
// - Macro OPL2_PHASE_KEYON_RESET_EN:
//   defined   -> key_rise zeroes acc_next (phase restart on note-on, chip-accurate).
//   undefined -> key_rise ignored; acc_next = acc + phase_inc always (free-running NCO);
//                key_prev still tracked so behaviour is identical apart from the reset term.
//
// TESTING
// 1. reset, then 4 strobes op 0, phase_inc=0x00400, key_on=1, mod=0 -> phase_out 0x001,0x002,
//    0x003,0x004 (with KEYON_RESET_EN first strobe yields 0x000, then 0x001..0x003).
// 2. op 5 acc preloaded to 0xFFC00 via strobes, phase_inc=0x00800 -> wraps to 0x00400,
//    phase_out=0x001; no X, no carry into other slots.
// 3. Interleave ops 0..17 with distinct phase_inc=(op+1)<<10 for 3 rounds -> op k phase_out
//    3*(k+1) in round 3; op_num_out matches; phase_valid one cycle per strobe.
// 4. op 2 running (acc=0x12345), key_on 0->1 with macro defined -> phase_out=mod only, acc=0;
//    macro undefined -> acc=0x12345+phase_inc.
// 5. modulation=-1 (0x3FF) with acc MSBs=0x000 -> phase_out=0x3FF; modulation=+0x1FF with
//    MSBs 0x300 -> 0x0FF (wrap).
// 6. Assert reset mid-round between strobes -> outputs 0 same cycle; op_num=19 strobe -> no valid.

Source files
------------

// File: rtl/op_phase_accumulator.sv
// Per-operator phase accumulator (NCO core) for time-multiplexed operator slots.
// Optional feature macro: OPL2_PHASE_KEYON_RESET_EN (restart phase on key-on rising edge).
module op_phase_accumulator #(
  parameter int NUM_OPS         = 18,
  parameter int PHASE_ACC_WIDTH = 20,
  parameter int PHASE_OUT_WIDTH = 10,
  parameter int MOD_WIDTH       = 10,
  parameter int OP_W            = $clog2(NUM_OPS)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_sample_clk_en,
  input  logic [OP_W-1:0]            i_op_num,
  input  logic [PHASE_ACC_WIDTH-1:0] i_phase_inc,
  input  logic                       i_key_on,
  input  logic [MOD_WIDTH-1:0]       i_modulation,
  output logic [PHASE_OUT_WIDTH-1:0] o_phase_out,
  output logic [OP_W-1:0]            o_op_num_out,
  output logic                       o_phase_valid
);

  localparam logic [OP_W-1:0] LAST_OP = OP_W'(NUM_OPS - 1);

  logic [PHASE_ACC_WIDTH-1:0] r_acc [NUM_OPS];
  logic [NUM_OPS-1:0]         r_key_prev;
  logic [PHASE_OUT_WIDTH-1:0] r_phase_out;
  logic [OP_W-1:0]            r_op_num_out;
  logic                       r_phase_valid;

  logic                       w_in_range;
  logic                       w_strobe;
  logic [OP_W-1:0]            w_idx;
  logic                       w_key_rise;
  logic [PHASE_ACC_WIDTH-1:0] w_acc_sum;
  logic [PHASE_ACC_WIDTH-1:0] w_acc_next;
  logic [PHASE_OUT_WIDTH-1:0] w_mod_ext;

  assign w_in_range = (i_op_num <= LAST_OP);
  assign w_strobe   = i_sample_clk_en & w_in_range;
  // Clamp the read index so an out-of-range op_num never addresses past the array.
  assign w_idx      = w_in_range ? i_op_num : '0;
  assign w_key_rise = i_key_on & ~r_key_prev[w_idx];
  assign w_acc_sum  = r_acc[w_idx] + i_phase_inc;

`ifdef OPL2_PHASE_KEYON_RESET_EN
  assign w_acc_next = w_key_rise ? '0 : w_acc_sum;
`else
  logic w_unused_key_rise;
  assign w_unused_key_rise = w_key_rise;
  assign w_acc_next        = w_acc_sum;
`endif

  generate
    if (MOD_WIDTH >= PHASE_OUT_WIDTH) begin : g_mod_trunc
      assign w_mod_ext = i_modulation[PHASE_OUT_WIDTH-1:0];
    end else begin : g_mod_sext
      assign w_mod_ext = {{(PHASE_OUT_WIDTH-MOD_WIDTH){i_modulation[MOD_WIDTH-1]}}, i_modulation};
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        r_acc[i] <= '0;
      end
      r_key_prev    <= '0;
      r_phase_out   <= '0;
      r_op_num_out  <= '0;
      r_phase_valid <= 1'b0;
    end else begin
      r_phase_valid <= 1'b0;
      if (w_strobe) begin
        r_acc[w_idx]      <= w_acc_next;
        r_key_prev[w_idx] <= i_key_on;
        r_phase_valid     <= 1'b1;
        r_op_num_out      <= i_op_num;
        r_phase_out       <= w_acc_next[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + w_mod_ext;
      end
    end
  end

  assign o_phase_out   = r_phase_out;
  assign o_op_num_out  = r_op_num_out;
  assign o_phase_valid = r_phase_valid;

endmodule

// File: tb/tb_op_phase_accumulator.sv
// Directed self-checking bench for op_phase_accumulator; expectations follow
// OPL2_PHASE_KEYON_RESET_EN when it is defined for the build.
module tb_op_phase_accumulator;

`ifdef OPL2_PHASE_KEYON_RESET_EN
  localparam bit KRST = 1'b1;
`else
  localparam bit KRST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_clk_en = 1'b0;
  logic [4:0]  op_num = '0;
  logic [19:0] phase_inc = '0;
  logic        key_on = 1'b0;
  logic [9:0]  modulation = '0;
  logic [9:0]  phase_out;
  logic [4:0]  op_num_out;
  logic        phase_valid;

  int n_tests = 0;
  int n_fail  = 0;

  op_phase_accumulator dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_sample_clk_en (sample_clk_en),
    .i_op_num        (op_num),
    .i_phase_inc     (phase_inc),
    .i_key_on        (key_on),
    .i_modulation    (modulation),
    .o_phase_out     (phase_out),
    .o_op_num_out    (op_num_out),
    .o_phase_valid   (phase_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic strobe(input logic [4:0] op, input logic [19:0] inc,
                        input logic key, input logic [9:0] mod);
    @(negedge clk);
    sample_clk_en = 1'b1;
    op_num        = op;
    phase_inc     = inc;
    key_on        = key;
    modulation    = mod;
    @(posedge clk);
    #1;
    sample_clk_en = 1'b0;
  endtask

  task automatic strobe_chk(input string tag, input logic [4:0] op, input logic [19:0] inc,
                            input logic key, input logic [9:0] mod, input int unsigned exp);
    strobe(op, inc, key, mod);
    chk({tag, "_valid"}, phase_valid, 1);
    chk({tag, "_op"}, op_num_out, op);
    chk({tag, "_phase"}, phase_out, exp);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", phase_valid, 0);
    chk("rst_phase", phase_out, 0);
    chk("rst_op", op_num_out, 0);
    do_reset();

    // 1: op 0 counting up
    strobe_chk("t1_s0", 5'd0, 20'h00400, 1'b1, 10'h000, KRST ? 32'h000 : 32'h001);
    strobe_chk("t1_s1", 5'd0, 20'h00400, 1'b1, 10'h000, KRST ? 32'h001 : 32'h002);
    strobe_chk("t1_s2", 5'd0, 20'h00400, 1'b1, 10'h000, KRST ? 32'h002 : 32'h003);
    strobe_chk("t1_s3", 5'd0, 20'h00400, 1'b1, 10'h000, KRST ? 32'h003 : 32'h004);
    @(posedge clk); #1;
    chk("t1_idle_valid", phase_valid, 0);
    chk("t1_idle_hold", phase_out, KRST ? 32'h003 : 32'h004);

    // 2: op 5 wrap, other slot untouched
    strobe_chk("t2_pre", 5'd5, 20'hFFC00, 1'b0, 10'h000, 32'h3FF);
    strobe_chk("t2_wrap", 5'd5, 20'h00800, 1'b0, 10'h000, 32'h001);
    strobe_chk("t2_op0", 5'd0, 20'h00000, 1'b1, 10'h000, KRST ? 32'h003 : 32'h004);

    // 3: interleaved slots, three rounds
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      for (int k = 0; k < 18; k++) begin
        if (r < 3) strobe(5'(k), 20'((k + 1) << 10), 1'b0, 10'h000);
        else strobe_chk("t3_r3", 5'(k), 20'((k + 1) << 10), 1'b0, 10'h000, 32'(3 * (k + 1)));
      end
    end
    @(posedge clk); #1;
    chk("t3_valid_end", phase_valid, 0);

    // 4: key-on edge on a running slot
    do_reset();
    strobe_chk("t4_load", 5'd2, 20'h12345, 1'b0, 10'h000, 32'h048);
    strobe_chk("t4_keyon", 5'd2, 20'h00100, 1'b1, 10'h005, KRST ? 32'h005 : 32'h04E);
    strobe_chk("t4_held", 5'd2, 20'h00000, 1'b1, 10'h000, KRST ? 32'h000 : 32'h049);
    strobe_chk("t4_keyoff", 5'd2, 20'h00400, 1'b0, 10'h000, KRST ? 32'h001 : 32'h04A);

    // 5: signed modulation with wrap
    do_reset();
    strobe_chk("t5_neg1", 5'd7, 20'h00000, 1'b0, 10'h3FF, 32'h3FF);
    strobe_chk("t5_load", 5'd7, 20'hC0000, 1'b0, 10'h000, 32'h300);
    strobe_chk("t5_wrap", 5'd7, 20'h00000, 1'b0, 10'h1FF, 32'h0FF);

    // 6: reset mid-round, then out-of-range op_num
    strobe_chk("t6_pre", 5'd3, 20'h00400, 1'b0, 10'h000, 32'h001);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", phase_valid, 0);
    chk("t6_rst_phase", phase_out, 0);
    chk("t6_rst_op", op_num_out, 0);
    @(negedge clk);
    reset = 1'b0;
    strobe_chk("t6_restart", 5'd3, 20'h00400, 1'b0, 10'h000, 32'h001);
    strobe(5'd19, 20'h40000, 1'b1, 10'h000);
    chk("t6_oor_valid", phase_valid, 0);
    chk("t6_oor_hold", phase_out, 32'h001);
    chk("t6_oor_op", op_num_out, 32'd3);
    strobe_chk("t6_op0", 5'd0, 20'h00000, 1'b0, 10'h000, 32'h000);
    strobe_chk("t6_op3", 5'd3, 20'h00000, 1'b0, 10'h000, 32'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
